// File: rtl/eep_pkg.sv
// Shared definitions for the instruction encoder: request kinds, FSM states,
// the extension-word prefix and the fixed opcode-class bit patterns.
package eep_pkg;

   // Request kinds carried on in_kind; codes 6 and 7 are undefined.
   typedef enum logic [2:0] {
      ALU_REG = 3'd0,
      ALU_IMM = 3'd1,
      SHIFT   = 3'd2,
      LDR     = 3'd3,
      STR     = 3'd4,
      JMP     = 3'd5
   } kind_e;

   // Emitter states: waiting for a request, presenting the extension word,
   // presenting the instruction word.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EMIT_EXT = 2'd1,
      EMIT_INS = 2'd2
   } state_e;

   localparam logic [7:0] EXT_PREFIX = 8'hD0;
   localparam logic [3:0] OPC_SHIFT  = 4'b0111;
   localparam logic [2:0] OPC_LDR    = 3'b100;
   localparam logic [2:0] OPC_STR    = 3'b101;
   localparam logic [3:0] OPC_JMP    = 4'b1100;

   // ALU opcode with no instruction behind it; requests using it are rejected.
   localparam logic [2:0] ALUOP_BAD  = 3'b111;

endpackage

// File: rtl/insencode_imm_fits.sv
// Signed range check: a REG_WIDTH value fits a FIELD_W-bit signed field when
// every bit from the top down to the field's sign bit has the same value.
module imm_fits #(
   parameter int REG_WIDTH = 16,
   parameter int FIELD_W   = 8
) (
   input  logic [REG_WIDTH-1:0] i_val,
   output logic                 o_fits
);

   logic [REG_WIDTH-FIELD_W:0] w_upper;

   assign w_upper = i_val[REG_WIDTH-1:FIELD_W-1];
   assign o_fits  = (&w_upper) | ~(|w_upper);

endmodule

// File: rtl/insencode.sv
// Instruction encoder: accepts one encode request at a time, emits either a
// single instruction word or an extension word followed by the instruction
// word, and numbers every accepted output word with a running address.
module insencode
   import eep_pkg::*;
#(
   parameter int REG_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           in_kind,
   input  logic [2:0]           in_aluop,
   input  logic [2:0]           in_a,
   input  logic [2:0]           in_b,
   input  logic [2:0]           in_c,
   input  logic [REG_WIDTH-1:0] in_imm,
   input  logic [3:0]           in_scnt,
   input  logic [1:0]           in_shop,
   input  logic [3:0]           in_cond,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [REG_WIDTH-1:0] out_word,
   output logic [15:0]          out_addr,
   output logic                 err
);

   state_e               r_state;
   logic                 r_out_valid;
   logic                 r_err;
   logic [REG_WIDTH-1:0] r_out_word;
   logic [REG_WIDTH-1:0] r_ins_word;
   logic [15:0]          r_out_addr;

   logic                 w_fits8;
   logic                 w_fits5;
   logic                 w_fire;
   logic                 w_reject;
   logic                 w_need_ext;
   logic [REG_WIDTH-1:0] w_ins_word;
   logic [REG_WIDTH-1:0] w_ext_word;

   imm_fits #(.REG_WIDTH(REG_WIDTH), .FIELD_W(8)) u_fits8 (
      .i_val  (in_imm),
      .o_fits (w_fits8)
   );

   imm_fits #(.REG_WIDTH(REG_WIDTH), .FIELD_W(5)) u_fits5 (
      .i_val  (in_imm),
      .o_fits (w_fits5)
   );

   assign in_ready   = (r_state == IDLE);
   assign w_fire     = r_out_valid & out_ready;
   assign w_ext_word = {EXT_PREFIX, in_imm[15:8]};

   assign out_valid  = r_out_valid;
   assign out_word   = r_out_word;
   assign out_addr   = r_out_addr;
   assign err        = r_err;

   // Decode the request on the inputs into its instruction word and routing.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (which would infer a latch).
      w_ins_word = '0;
      w_reject   = 1'b0;
      w_need_ext = 1'b0;
      case (in_kind)
         ALU_REG: begin
            w_reject   = (in_aluop == ALUOP_BAD);
            w_ins_word = {1'b0, in_aluop, in_a, 1'b0, in_b, in_c, 2'b00};
         end
         ALU_IMM: begin
            w_reject   = (in_aluop == ALUOP_BAD);
            w_need_ext = ~w_fits8;
            w_ins_word = {1'b0, in_aluop, in_a, 1'b1, in_imm[7:0]};
         end
         SHIFT: begin
            w_ins_word = {OPC_SHIFT, in_a, in_shop[1], in_b, in_shop[0], in_scnt};
         end
         LDR: begin
            w_reject   = ~w_fits5;
            w_ins_word = {OPC_LDR, 1'b0, in_a, 1'b0, in_b, in_imm[4:0]};
         end
         STR: begin
            w_reject   = ~w_fits5;
            w_ins_word = {OPC_STR, 1'b0, in_a, 1'b0, in_b, in_imm[4:0]};
         end
         JMP: begin
            w_need_ext = ~w_fits8;
            w_ins_word = {OPC_JMP, in_cond, in_imm[7:0]};
         end
         default: begin
            w_reject = 1'b1;
         end
      endcase
   end

   // Emitter FSM: accept in IDLE, hold each word until the consumer takes it.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_state     <= IDLE;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
         r_out_word  <= '0;
         r_ins_word  <= '0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  if (w_reject) begin
                     r_err <= 1'b1;
                  end else if (w_need_ext) begin
                     r_out_word  <= w_ext_word;
                     r_ins_word  <= w_ins_word;
                     r_out_valid <= 1'b1;
                     r_state     <= EMIT_EXT;
                  end else begin
                     r_out_word  <= w_ins_word;
                     r_out_valid <= 1'b1;
                     r_state     <= EMIT_INS;
                  end
               end
            end
            EMIT_EXT: begin
               if (w_fire) begin
                  r_out_word <= r_ins_word;
                  r_state    <= EMIT_INS;
               end
            end
            EMIT_INS: begin
               if (w_fire) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   // Output address: advances once per accepted word, wrapping at 16 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_addr <= '0;
      end else if (w_fire) begin
         r_out_addr <= r_out_addr + 16'd1;
      end
   end

endmodule
